// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXE/MEM/WB) with memory ready handshakes
// and a retired-instruction counter. Define MC_JUMP_EN to make JAL/JALR legal instructions.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrCode,
    input  logic             instrReady,
    input  logic             compare,
    input  logic             dataReady,
    output logic             instrReq,
    output logic             irEn,
    output logic             pcEn,
    output logic             PCAddrSrcMuxSel,
    output logic             regFileWe,
    output logic [3:0]       aluControl,
    output logic             aluSrcMuxSel,
    output logic             alurd1MuxSel,
    output logic             dataReq,
    output logic             dataWe,
    output logic             wdataSel,
    output logic             lui,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LU   = 7'b0110111;
    localparam logic [6:0] OP_AU   = 7'b0010111;
`ifdef MC_JUMP_EN
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    logic       is_r, is_i, is_s, is_l, is_b, is_lu, is_au, is_j, legal;
    logic       unused_bits;

    logic [3:0] alu_c;
    logic       asrc_c, rd1_c, lui_c;

    assign opcode      = instrCode[6:0];
    assign f3          = instrCode[14:12];
    assign f7b5        = instrCode[30];
    assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    assign is_r  = (opcode == OP_R);
    assign is_i  = (opcode == OP_I);
    assign is_s  = (opcode == OP_S);
    assign is_l  = (opcode == OP_L);
    assign is_b  = (opcode == OP_B);
    assign is_lu = (opcode == OP_LU);
    assign is_au = (opcode == OP_AU);
`ifdef MC_JUMP_EN
    assign is_j  = (opcode == OP_JAL) || (opcode == OP_JALR);
`else
    assign is_j  = 1'b0;
`endif
    assign legal = is_r | is_i | is_s | is_l | is_b | is_lu | is_au | is_j;

    // Datapath selects depend only on the opcode; they are gated by state below.
    always_comb begin
        alu_c  = ALU_ADD;
        asrc_c = 1'b0;
        rd1_c  = 1'b0;
        lui_c  = 1'b0;
        if (is_r) begin
            alu_c = {f7b5, f3};
        end else if (is_i) begin
            asrc_c = 1'b1;
            alu_c  = (f3 == 3'b101 && f7b5) ? ALU_SRA : {1'b0, f3};
        end else if (is_b) begin
            case (f3[2:1])
                2'b10:   alu_c = ALU_SLT;
                2'b11:   alu_c = ALU_SLTU;
                default: alu_c = ALU_BEQ;
            endcase
        end else if (is_s || is_l) begin
            asrc_c = 1'b1;
        end else if (is_lu) begin
            asrc_c = 1'b1;
            lui_c  = 1'b1;
        end else if (is_au || is_j) begin
            asrc_c = 1'b1;
            rd1_c  = 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        instrReq        = 1'b0;
        irEn            = 1'b0;
        pcEn            = 1'b0;
        PCAddrSrcMuxSel = 1'b0;
        regFileWe       = 1'b0;
        aluControl      = 4'b0000;
        aluSrcMuxSel    = 1'b0;
        alurd1MuxSel    = 1'b0;
        dataReq         = 1'b0;
        dataWe          = 1'b0;
        wdataSel        = 1'b0;
        lui             = 1'b0;
        if (!reset) begin
            if (state != FETCH && legal) begin
                aluControl   = alu_c;
                aluSrcMuxSel = asrc_c;
                alurd1MuxSel = rd1_c;
                lui          = lui_c;
            end
            case (state)
                FETCH: begin
                    instrReq = 1'b1;
                    if (instrReady) begin
                        irEn      = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    // Unknown opcodes retire here as a NOP.
                    if (legal) begin
                        state_nxt = EXE;
                    end else begin
                        pcEn      = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                EXE: begin
                    if (is_s || is_l) begin
                        state_nxt = MEM;
                    end else if (is_b) begin
                        pcEn            = 1'b1;
                        PCAddrSrcMuxSel = compare ^ f3[0];
                        state_nxt       = FETCH;
                    end else begin
                        regFileWe       = 1'b1;
                        pcEn            = 1'b1;
                        PCAddrSrcMuxSel = is_j;
                        state_nxt       = FETCH;
                    end
                end
                MEM: begin
                    dataReq = 1'b1;
                    dataWe  = is_s;
                    if (dataReady) begin
                        if (is_s) begin
                            pcEn      = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = WB;
                        end
                    end
                end
                WB: begin
                    regFileWe = 1'b1;
                    wdataSel  = 1'b1;
                    pcEn      = 1'b1;
                    state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (pcEn) count <= count + CNT_W'(1);
        end
    end

    assign instret = reset ? '0 : count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: per-instruction expectations are
// queued by the driver and retired by a monitor that watches the pcEn pulse.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        instrReady, compare, dataReady;
  logic        instrReq, irEn, pcEn, PCAddrSrcMuxSel, regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel, alurd1MuxSel, dataReq, dataWe, wdataSel, lui;
  logic [31:0] instret;

  logic        s_instrReq, s_irEn, s_pcEn, s_pcsrc, s_regFileWe;
  logic [3:0]  s_aluControl;
  logic        s_asrc, s_rd1, s_dataReq, s_dataWe, s_wdataSel, s_lui;
  logic [2:0]  s_instret;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .instrReady(instrReady),
    .compare(compare), .dataReady(dataReady), .instrReq(instrReq), .irEn(irEn),
    .pcEn(pcEn), .PCAddrSrcMuxSel(PCAddrSrcMuxSel), .regFileWe(regFileWe),
    .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel), .alurd1MuxSel(alurd1MuxSel),
    .dataReq(dataReq), .dataWe(dataWe), .wdataSel(wdataSel), .lui(lui), .instret(instret)
  );

  // Narrow counter copy so the wrap to zero is reached within a short run.
  multicycle_control_fsm #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .instrCode(instrCode), .instrReady(instrReady),
    .compare(compare), .dataReady(dataReady), .instrReq(s_instrReq), .irEn(s_irEn),
    .pcEn(s_pcEn), .PCAddrSrcMuxSel(s_pcsrc), .regFileWe(s_regFileWe),
    .aluControl(s_aluControl), .aluSrcMuxSel(s_asrc), .alurd1MuxSel(s_rd1),
    .dataReq(s_dataReq), .dataWe(s_dataWe), .wdataSel(s_wdataSel), .lui(s_lui),
    .instret(s_instret)
  );

  localparam logic [2:0] K_NOP = 3'd0, K_WR = 3'd1, K_B = 3'd2, K_S = 3'd3, K_L = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  cycles, req_cyc, dreq_cyc, dwe_cyc, rwe_cyc, wsel_cyc;
    logic        pcsrc;
    logic [3:0]  alu;
    logic        chk_alu, asrc, rd1, lui;
    logic [31:0] ret;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] model_ret = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: instruction class, cycle budget and write activity from the ISA-level rules.
  function automatic exp_t model(input logic [31:0] code, input int f, input int d,
                                 input logic cmp, input logic [31:0] ret);
    exp_t e;
    logic [2:0] f3;
    e = '0;
    f3 = code[14:12];
    e.ret = ret;
    e.req_cyc = 8'(f + 1);
    e.chk_alu = 1'b1;
    e.kind = K_NOP;
    case (code[6:0])
      7'b0110011: begin e.kind = K_WR; e.alu = {code[30], f3}; end
      7'b0010011: begin
        e.kind = K_WR; e.asrc = 1'b1;
        e.alu = (f3 == 3'd5 && code[30]) ? 4'b1101 : {1'b0, f3};
      end
      7'b0110111: begin e.kind = K_WR; e.lui = 1'b1; e.chk_alu = 1'b0; end
      7'b0010111: begin e.kind = K_WR; e.asrc = 1'b1; e.rd1 = 1'b1; end
      7'b1100011: begin
        e.kind = K_B; e.pcsrc = cmp ^ f3[0];
        e.alu = (f3[2:1] == 2'b10) ? 4'b0010 : (f3[2:1] == 2'b11) ? 4'b0011 : 4'b1000;
      end
      7'b0100011: begin e.kind = K_S; e.asrc = 1'b1; end
      7'b0000011: begin e.kind = K_L; e.asrc = 1'b1; end
`ifdef MC_JUMP_EN
      7'b1101111, 7'b1100111: begin
        e.kind = K_WR; e.asrc = 1'b1; e.rd1 = 1'b1; e.pcsrc = 1'b1;
      end
`endif
      default: e.kind = K_NOP;
    endcase
    case (e.kind)
      K_NOP: e.cycles = 8'(f + 2);
      K_WR:  begin e.cycles = 8'(f + 3); e.rwe_cyc = 8'd1; end
      K_B:   e.cycles = 8'(f + 3);
      K_S:   begin e.cycles = 8'(f + d + 4); e.dreq_cyc = 8'(d + 1); e.dwe_cyc = 8'(d + 1); end
      default: begin
        e.cycles = 8'(f + d + 5); e.dreq_cyc = 8'(d + 1); e.rwe_cyc = 8'd1; e.wsel_cyc = 8'd1;
      end
    endcase
    return e;
  endfunction

  task automatic drive(input logic ir, input logic dr, input logic cm);
    instrReady = ir;
    dataReady = dr;
    compare = cm;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] code, input int f, input int d, input int cmp);
    exp_t e;
    logic cmp_exe;
    cmp_exe = (cmp < 0) ? 1'($urandom_range(1)) : 1'(cmp);
    e = model(code, f, d, cmp_exe, model_ret);
    exp_q.push_back(e);
    model_ret = model_ret + 1;
    instrCode = code;
    repeat (f) drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
    drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    if (e.kind != K_NOP) drive(1'($urandom_range(1)), 1'($urandom_range(1)), cmp_exe);
    if (e.kind == K_S || e.kind == K_L) begin
      repeat (d) drive(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)));
      drive(1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)));
    end
    if (e.kind == K_L) drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  // Monitor
  initial begin
    int cyc, req_c, ir_c, dreq_c, dwe_c, rwe_c, wsel_c;
    bit after_rst;
    exp_t e;
    cyc = 0; req_c = 0; ir_c = 0; dreq_c = 0; dwe_c = 0; rwe_c = 0; wsel_c = 0;
    after_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outputs", {instrReq, irEn, pcEn, PCAddrSrcMuxSel, regFileWe, aluControl,
              aluSrcMuxSel, alurd1MuxSel, dataReq, dataWe, wdataSel, lui}, 0);
        check("reset_instret", instret, 0);
        check("reset_small_outputs", {s_instrReq, s_irEn, s_pcEn, s_pcsrc, s_regFileWe, s_aluControl,
              s_asrc, s_rd1, s_dataReq, s_dataWe, s_wdataSel, s_lui, s_instret}, 0);
        cyc = 0; req_c = 0; ir_c = 0; dreq_c = 0; dwe_c = 0; rwe_c = 0; wsel_c = 0;
        after_rst = 1'b1;
      end else begin
        if (after_rst) begin
          check("fetch_after_reset", instrReq, 1);
          after_rst = 1'b0;
        end
        check("we_exclusive", regFileWe & dataWe, 0);
        cyc++;
        req_c += int'(instrReq); ir_c += int'(irEn); dreq_c += int'(dataReq);
        dwe_c += int'(dataWe); rwe_c += int'(regFileWe); wsel_c += int'(wdataSel);
        if (instrReq) begin
          check("fetch_quiet", {pcEn, regFileWe, dataReq, dataWe, wdataSel, lui, aluControl,
                aluSrcMuxSel, alurd1MuxSel, PCAddrSrcMuxSel}, 0);
        end else if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (e.chk_alu) begin
            check("alu_control", aluControl, e.alu);
            check("alu_src_sel", aluSrcMuxSel, e.asrc);
          end
          check("alu_rd1_sel", alurd1MuxSel, e.rd1);
          check("lui_sel", lui, e.lui);
        end
        if (pcEn) begin
          check("retire_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cycles", cyc, e.cycles);
            check("fetch_cycles", req_c, e.req_cyc);
            check("ir_load_count", ir_c, 1);
            check("regfile_we_cycles", rwe_c, e.rwe_cyc);
            check("data_req_cycles", dreq_c, e.dreq_cyc);
            check("data_we_cycles", dwe_c, e.dwe_cyc);
            check("wdata_sel_cycles", wsel_c, e.wsel_cyc);
            check("pc_src", PCAddrSrcMuxSel, e.pcsrc);
            check("instret", instret, e.ret);
            check("instret_small", s_instret, e.ret[2:0]);
          end
          cyc = 0; req_c = 0; ir_c = 0; dreq_c = 0; dwe_c = 0; rwe_c = 0; wsel_c = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    logic [6:0]  ops[10];
    logic [31:0] code;
    int qwait;
    ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};
    reset = 1'b1; instrCode = '0; instrReady = 1'b0; compare = 1'b0; dataReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Store interrupted by reset while waiting in MEM; it must never retire.
    exp_q.push_back(model(32'h0050A223, 0, 5, 1'b0, model_ret));
    instrCode = 32'h0050A223;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    model_ret = 0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    reset = 1'b0;

    issue(32'h002081B3, 0, 0, -1);
    issue(32'h0000A283, 0, 3, -1);
    issue(32'h0050A223, 0, 0, -1);
    issue(32'h00000463, 0, 0, 1);
    issue(32'h00000463, 0, 0, 0);
    issue(32'h00001463, 0, 0, 1);
    issue(32'h0000007F, 0, 0, -1);
    issue(32'h4050D093, 1, 0, -1);
    issue(32'h0000006F, 0, 0, -1);

    for (int i = 0; i < 120; i++) begin
      code = $urandom;
      if ($urandom_range(9) == 0) code[6:0] = 7'($urandom);
      else code[6:0] = ops[$urandom_range(9)];
      if (code[6:0] == 7'b1100011 && code[14:13] == 2'b01) code[13] = 1'b0;
      issue(code, $urandom_range(3), $urandom_range(3), -1);
    end

    qwait = 0;
    while (exp_q.size() != 0 && qwait < 50) begin
      drive(1'b0, 1'b0, 1'b0);
      qwait++;
    end
    check("queue_drained", exp_q.size(), 0);
    drive(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It replaces the single-cycle decode-only control path. The block walks each instruction through FETCH/DECODE/EXE/MEM/WB states and drives the datapath mux selects and write enables in the proper state only. It adds ready handshakes to instruction and data memory, plus a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
instrCode  in  32  instruction register contents, valid from DECODE onward
instrReady  in  1  instruction memory read data valid
compare  in  1  ALU branch compare result
dataReady  in  1  data memory access complete
instrReq  out  1  instruction fetch request
irEn  out  1  instruction register load enable
pcEn  out  1  PC register update enable
PCAddrSrcMuxSel  out  1  0=PC+4, 1=branch/jump target
regFileWe  out  1  register file write enable
aluControl  out  4  ALU op, encodings from defines.sv
aluSrcMuxSel  out  1  0=rs2, 1=immediate
alurd1MuxSel  out  1  0=rs1, 1=PC
dataReq  out  1  data memory request
dataWe  out  1  data memory write enable
wdataSel  out  1  0=ALU result, 1=load data
lui  out  1  write-back selects immediate
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (sync, active-high, priority over everything): state=FETCH, instret=0. While reset=1, every output is 0.
- Outputs are combinational from state and instrCode; state and instret are registered.
- aluSrcMuxSel, alurd1MuxSel, aluControl and lui are driven per opcode in DECODE/EXE/MEM/WB. Encodings follow the core decode table: R uses {f7[5],f3}; I uses {0,f3}, except SRAI {1,101}; S/L/AU use ADD; B f3[2:1] 00/10/11 maps to BEQ/SLT/SLTU.
- FETCH: instrReq=1. Wait while instrReady=0. On instrReady=1, irEn=1 and go to DECODE.
- DECODE: no enables asserted.
  - Legal opcodes (R,I,S,L,B,LU,AU) go to EXE.
  - Unknown opcode is a NOP: pcEn=1 in DECODE, go to FETCH, instret increments.
- EXE:
  - R/I/LU/AU: regFileWe=1, pcEn=1, go to FETCH.
  - B: pcEn=1, PCAddrSrcMuxSel=compare^f3[0], go to FETCH.
  - S/L: go to MEM.
- MEM: dataReq=1, dataWe=1 for S only. Hold all selects stable while dataReady=0.
  - On dataReady=1: S sets pcEn=1 and goes to FETCH; L goes to WB.
- WB (L only): regFileWe=1, wdataSel=1, pcEn=1, go to FETCH.
- Invariant: pcEn is high exactly one cycle per instruction, in its final state.
- instret increments in every cycle pcEn=1. It wraps 2^CNT_W-1 to 0.
- Latencies with ready=1 immediately: R/I/LU/AU/B take 3 cycles, S takes 4, L takes 5.
- Ready inputs are ignored outside their own state (instrReady outside FETCH, dataReady outside MEM).
- Reset asserted mid-MEM: dataReq and dataWe drop in the same cycle reset is sampled. The next state is FETCH.
- regFileWe and dataWe are never both 1.

Optional Feature:
MC_JUMP_EN:
- Defined: JAL (1101111) and JALR (1100111) are legal.
  - EXE: regFileWe=1, lui=0, alurd1MuxSel=1, aluSrcMuxSel=1, aluControl=ADD (PC+4 link via datapath), PCAddrSrcMuxSel=1, pcEn=1. Then go to FETCH.
- Undefined: both opcodes are treated as unknown-opcode NOPs.

Test Plan:
- Reset held 2 cycles mid-MEM of a store, release -> all outputs 0 during reset; state FETCH and instrReq=1 the cycle after release; instret=0.
- add x3,x1,x2 (0x002081B3), instrReady=1 -> irEn in cycle 1; EXE in cycle 3 with regFileWe=1, aluControl=0000, pcEn=1; instret=1.
- lw x5,0(x1) (0x0000A283), dataReady delayed 3 cycles -> dataReq held 4 cycles with dataWe=0; WB regFileWe=1, wdataSel=1; total 8 cycles; single pcEn pulse.
- sw x5,4(x1) (0x0050A223), dataReady=1 -> MEM dataReq=1, dataWe=1, pcEn=1; regFileWe never 1; 4 cycles.
- beq x0,x0,8 (0x00000463): compare=1 gives PCAddrSrcMuxSel=1; compare=0 gives 0. bne (0x00001463) with compare=1 gives 0.
- Opcode 0x0000007F -> pcEn=1 in DECODE, no writes, instret increments. Run 0xFFFFFFFF retirements with CNT_W=32 forced near max -> instret wraps to 0.
